// File: rtl/mux_pkg.sv
// Shared constants and select-packing helper for the 16:1 registered multiplexer.
package mux_pkg;

    localparam int NUM_IN = 16;
    localparam int SEL_W  = 4;

    // s0 is the MSB, s3 the LSB of the packed select.
    function automatic logic [SEL_W-1:0] pack_sel(input logic s0, input logic s1,
                                                  input logic s2, input logic s3);
        return {s0, s1, s2, s3};
    endfunction

endpackage

// File: rtl/mux_4to1.sv
// Combinational 4:1 multiplexer leaf used to build the 16:1 select tree.
module mux_4to1 #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    input  logic [1:0]   sel,
    output logic [N-1:0] y
);

    always_comb begin
        y = a;
        unique case (sel)
            2'd0: y = a;
            2'd1: y = b;
            2'd2: y = c;
            2'd3: y = d;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/mux_16to1.sv
// Registered 16:1 multiplexer: two-level 4:1 tree feeding a single output register.
module mux_16to1
    import mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i1,
    input  logic [N-1:0] i2,
    input  logic [N-1:0] i3,
    input  logic [N-1:0] i4,
    input  logic [N-1:0] i5,
    input  logic [N-1:0] i6,
    input  logic [N-1:0] i7,
    input  logic [N-1:0] i8,
    input  logic [N-1:0] i9,
    input  logic [N-1:0] i10,
    input  logic [N-1:0] i11,
    input  logic [N-1:0] i12,
    input  logic [N-1:0] i13,
    input  logic [N-1:0] i14,
    input  logic [N-1:0] i15,
    input  logic [N-1:0] i16,
    input  logic         s0,
    input  logic         s1,
    input  logic         s2,
    input  logic         s3,
    output logic [N-1:0] out
);

    logic [SEL_W-1:0] sel;
    logic [N-1:0]     grp [NUM_IN/4];
    logic [N-1:0]     sel_word;
    logic [N-1:0]     out_p0;

    assign sel = pack_sel(s0, s1, s2, s3);

    mux_4to1 #(.N(N)) u_grp0 (.a(i1),  .b(i2),  .c(i3),  .d(i4),  .sel(sel[1:0]), .y(grp[0]));
    mux_4to1 #(.N(N)) u_grp1 (.a(i5),  .b(i6),  .c(i7),  .d(i8),  .sel(sel[1:0]), .y(grp[1]));
    mux_4to1 #(.N(N)) u_grp2 (.a(i9),  .b(i10), .c(i11), .d(i12), .sel(sel[1:0]), .y(grp[2]));
    mux_4to1 #(.N(N)) u_grp3 (.a(i13), .b(i14), .c(i15), .d(i16), .sel(sel[1:0]), .y(grp[3]));

    mux_4to1 #(.N(N)) u_root (
        .a   (grp[0]),
        .b   (grp[1]),
        .c   (grp[2]),
        .d   (grp[3]),
        .sel (sel[3:2]),
        .y   (sel_word)
    );

    // Stage p0: the only register; selection captured at the edge, reset clears it.
    always_ff @(posedge clk) begin
        if (rst)
            out_p0 <= '0;
        else
            out_p0 <= sel_word;
    end

    assign out = out_p0;

endmodule

// File: tb/tb_mux_16to1.sv
// Directed scoreboard bench for mux_16to1 at N=4 and N=1.
module tb_mux_16to1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       s0, s1, s2, s3;
    logic [3:0] iv [16];
    logic [0:0] bv [16];
    logic [3:0] out4;
    logic [0:0] out1;

    typedef struct {
        string      tag;
        logic [3:0] e4;
        logic [0:0] e1;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mux_16to1 #(.N(4)) dut4 (
        .clk(clk), .rst(rst),
        .i1(iv[0]),   .i2(iv[1]),   .i3(iv[2]),   .i4(iv[3]),
        .i5(iv[4]),   .i6(iv[5]),   .i7(iv[6]),   .i8(iv[7]),
        .i9(iv[8]),   .i10(iv[9]),  .i11(iv[10]), .i12(iv[11]),
        .i13(iv[12]), .i14(iv[13]), .i15(iv[14]), .i16(iv[15]),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3),
        .out(out4)
    );

    mux_16to1 #(.N(1)) dut1 (
        .clk(clk), .rst(rst),
        .i1(bv[0]),   .i2(bv[1]),   .i3(bv[2]),   .i4(bv[3]),
        .i5(bv[4]),   .i6(bv[5]),   .i7(bv[6]),   .i8(bv[7]),
        .i9(bv[8]),   .i10(bv[9]),  .i11(bv[10]), .i12(bv[11]),
        .i13(bv[12]), .i14(bv[13]), .i15(bv[14]), .i16(bv[15]),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3),
        .out(out1)
    );

    task automatic push_exp(input logic r, input logic [3:0] sel, input string tag);
        exp_t e;
        e.tag = tag;
        e.e4  = r ? 4'd0 : iv[sel];
        e.e1  = r ? 1'b0 : bv[sel];
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=%0d required=1", sb.size());
        end else begin
            e = sb.pop_front();
            total++;
            assert (out4 === e.e4) else begin
                bad++;
                $error("FAIL %s_n4 observed=%0d required=%0d", e.tag, out4, e.e4);
            end
            total++;
            assert (out1 === e.e1) else begin
                bad++;
                $error("FAIL %s_n1 observed=%0d required=%0d", e.tag, out1, e.e1);
            end
        end
    endtask

    // Drive one selection, expect it on the following edge.
    task automatic step(input logic r, input logic [3:0] sel, input string tag);
        rst = r;
        {s0, s1, s2, s3} = sel;
        push_exp(r, sel, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        rst = 1'b1;
        {s0, s1, s2, s3} = 4'd0;
        for (int k = 0; k < 16; k++) begin
            iv[k] = 4'((k + 1) % 16);
            bv[k] = 1'((k + 1) % 2);
        end
        @(posedge clk);
        #1;

        // Reset held for two edges with a non-zero select.
        step(1'b1, 4'd5, "rst_a");
        step(1'b1, 4'd9, "rst_b");
        step(1'b0, 4'd0, "rel_sel0");

        // Full sweep, one selection per cycle.
        for (int s = 0; s < 16; s++)
            step(1'b0, 4'(s), $sformatf("sweep%0d", s));

        // Hold sel=10, change i11, then disturb every other input.
        step(1'b0, 4'b1010, "hold_i11_old");
        iv[10] = 4'd5;
        bv[10] = 1'b0;
        step(1'b0, 4'b1010, "hold_i11_new");
        for (int k = 0; k < 16; k++)
            if (k != 10) begin
                iv[k] = 4'd15;
                bv[k] = 1'b1;
            end
        step(1'b0, 4'b1010, "hold_isolate");
        for (int k = 0; k < 16; k++) begin
            iv[k] = 4'((k + 1) % 16);
            bv[k] = 1'((k + 1) % 2);
        end

        // Reset pulse in the middle of a sweep, then the same selection resumes.
        for (int s = 4; s < 7; s++)
            step(1'b0, 4'(s), $sformatf("mid%0d", s));
        step(1'b1, 4'd7, "mid_rst");
        step(1'b0, 4'd7, "mid_resume7");
        step(1'b0, 4'd8, "mid_resume8");

        // Select toggles between edges; only the value at the edge counts.
        rst = 1'b0;
        {s0, s1, s2, s3} = 4'd0;
        #2;
        {s0, s1, s2, s3} = 4'd15;
        #2;
        {s0, s1, s2, s3} = 4'd3;
        push_exp(1'b0, 4'd3, "glitch_sel3");
        @(posedge clk);
        #1;
        check_out();

        // Distinctive patterns to exercise the upper tree level.
        for (int k = 0; k < 16; k++) begin
            iv[k] = 4'($urandom_range(0, 15));
            bv[k] = 1'($urandom_range(0, 1));
        end
        step(1'b0, 4'd12, "rand_sel12");
        step(1'b0, 4'd2,  "rand_sel2");
        step(1'b0, 4'd14, "rand_sel14");
        step(1'b0, 4'd9,  "rand_sel9");

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_left observed=%0d required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
